qpsk_frame_scheduler: RTL and testbench

//  Frame sequencer in front of the 32b->2b QPSK symbol converter. Builds each burst as

---
 rtl/qpsk_frame_scheduler_pkg.sv | 31 +++
 rtl/qpsk_frame_scheduler_if.sv | 11 +
 rtl/qpsk_frame_scheduler_out_reg.sv | 35 +++
 rtl/qpsk_frame_scheduler.sv | 164 ++++++++++++++++
 tb/tb_qpsk_frame_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_frame_scheduler_pkg.sv
// Shared types and CRC helper for the QPSK frame scheduler.
// QPSK_FRAME_CRC_EN adds the CRC state to the state encoding.
package qpsk_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
`ifdef QPSK_FRAME_CRC_EN
    ST_CRC      = 3'd4,
`endif
    ST_GAP      = 3'd5
  } state_e;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // Non-reflected CRC-32 advanced by one 32-bit word, data MSB first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = (c << 1) ^ CRC32_POLY;
      else                 c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/qpsk_frame_scheduler_if.sv
// Word stream between upstream, scheduler and QPSK converter.
// The slave side carries no tlast: payload framing is done by word count.
interface qpsk_frame_scheduler_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/qpsk_frame_scheduler_out_reg.sv
// Single-slot registered output stage; holds its word while the sink stalls.
module qpsk_frame_out_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        din_last,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        slot_free
);
  logic [31:0] tdata_p0;
  logic        vld_p0;
  logic        last_p0;

  assign slot_free = !vld_p0 || m_tready;
  assign m_tdata   = tdata_p0;
  assign m_tvalid  = vld_p0;
  assign m_tlast   = last_p0;

  // p0: output slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdata_p0 <= '0;
      vld_p0   <= 1'b0;
      last_p0  <= 1'b0;
    end else if (slot_free) begin
      vld_p0  <= load;
      last_p0 <= load && din_last;
      if (load) tdata_p0 <= din;
    end
  end
endmodule

// File: rtl/qpsk_frame_scheduler.sv
// Burst framer ahead of the QPSK converter: preamble, sync, payload, optional CRC, gap.
// Define QPSK_FRAME_CRC_EN to append a CRC-32 word after the payload.
module qpsk_frame_scheduler
  import qpsk_frame_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int PRE_W      = 8,
  parameter int GAP_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_enable,
  input  logic [PRE_W-1:0]       cfg_preamble_words,
  input  logic [31:0]            cfg_preamble,
  input  logic [31:0]            cfg_sync_word,
  input  logic [LEN_W-1:0]       cfg_payload_len,
  qpsk_frame_scheduler_if.slave  s_axis,
  qpsk_frame_scheduler_if.master m_axis,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic                   underrun
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PRE_W-1:0] pre_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      pre_pat_q, sync_q;
  logic             slot_free, pay_hs, start, load, load_last, en_q;
  logic [31:0]      load_data;
`ifdef QPSK_FRAME_CRC_EN
  logic [31:0]      crc_q;
`endif

  assign s_axis.tready = (state_q == ST_PAYLOAD) && slot_free;
  assign pay_hs        = s_axis.tvalid && s_axis.tready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    start     = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    load_data = pre_pat_q;
    case (state_q)
      ST_IDLE: if (cfg_enable) start = 1'b1;
      ST_PREAMBLE: if (slot_free) begin
        load = 1'b1;
        if (cnt_q == LEN_W'(pre_q) - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_SYNC;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_SYNC: if (slot_free) begin
        load      = 1'b1;
        load_data = sync_q;
        cnt_d     = '0;
        if (len_q != '0) begin
          state_d = ST_PAYLOAD;
        end else begin
`ifdef QPSK_FRAME_CRC_EN
          state_d = ST_CRC;
`else
          load_last = 1'b1;
          state_d   = ST_GAP;
`endif
        end
      end
      ST_PAYLOAD: if (pay_hs) begin
        load      = 1'b1;
        load_data = s_axis.tdata;
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d = '0;
`ifdef QPSK_FRAME_CRC_EN
          state_d = ST_CRC;
`else
          load_last = 1'b1;
          state_d   = ST_GAP;
`endif
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
`ifdef QPSK_FRAME_CRC_EN
      ST_CRC: if (slot_free) begin
        load      = 1'b1;
        load_data = crc_q ^ CRC32_XOROUT;
        load_last = 1'b1;
        state_d   = ST_GAP;
      end
`endif
      // Gap timing starts only once the final word has left the output slot.
      ST_GAP: if (!m_axis.tvalid) begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d = '0;
          if (cfg_enable) start = 1'b1;
          else            state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = (cfg_preamble_words != '0) ? ST_PREAMBLE : ST_SYNC;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      en_q      <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      en_q    <= cfg_enable;
      busy    <= (state_d != ST_IDLE);
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast) frame_cnt <= frame_cnt + 16'd1;
      if (state_q == ST_IDLE && cfg_enable && !en_q)
        underrun <= 1'b0;
      else if (state_q == ST_PAYLOAD && slot_free && !s_axis.tvalid)
        underrun <= 1'b1;
    end
  end

  // Frame configuration is frozen at frame start so mid-frame edits cannot corrupt it.
  always_ff @(posedge clk) begin
    if (start) begin
      pre_q     <= cfg_preamble_words;
      pre_pat_q <= cfg_preamble;
      sync_q    <= cfg_sync_word;
      len_q     <= cfg_payload_len;
    end
`ifdef QPSK_FRAME_CRC_EN
    if (start)       crc_q <= CRC32_INIT;
    else if (pay_hs) crc_q <= crc32_word(crc_q, s_axis.tdata);
`endif
  end

  qpsk_frame_out_reg u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .din       (load_data),
    .din_last  (load_last),
    .m_tready  (m_axis.tready),
    .m_tdata   (m_axis.tdata),
    .m_tvalid  (m_axis.tvalid),
    .m_tlast   (m_axis.tlast),
    .slot_free (slot_free)
  );
endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// Scoreboard bench for qpsk_frame_scheduler: directed frames, stalls, underrun, reset.
module tb_qpsk_frame_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_preamble_words = '0;
  logic [31:0] cfg_preamble = 32'h33333333;
  logic [31:0] cfg_sync_word = 32'h1ACFFC1D;
  logic [15:0] cfg_payload_len = '0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        underrun;

  qpsk_frame_scheduler_if s_if ();
  qpsk_frame_scheduler_if m_if ();

  qpsk_frame_scheduler dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cfg_enable         (cfg_enable),
    .cfg_preamble_words (cfg_preamble_words),
    .cfg_preamble       (cfg_preamble),
    .cfg_sync_word      (cfg_sync_word),
    .cfg_payload_len    (cfg_payload_len),
    .s_axis             (s_if),
    .m_axis             (m_if),
    .busy               (busy),
    .frame_cnt          (frame_cnt),
    .underrun           (underrun)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [32:0]  exp_q[$];
  logic [31:0]  src_q[$];
  int           acc_cnt = 0;
  int           stall_at = 0;
  int           stall_len = 0;
  int           stall_rem = 0;
  int           srdy_seen = 0;
  bit           tready_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

`ifdef QPSK_FRAME_CRC_EN
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction
`endif

  task automatic push_frame(input int pre_n, input int len_n, input logic [31:0] base);
    logic [31:0] w;
    logic [31:0] crc;
    logic        lst;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < pre_n; i++) exp_q.push_back({1'b0, cfg_preamble});
`ifdef QPSK_FRAME_CRC_EN
    lst = 1'b0;
`else
    lst = (len_n == 0);
`endif
    exp_q.push_back({lst, cfg_sync_word});
    for (int i = 0; i < len_n; i++) begin
      w = base + i;
      src_q.push_back(w);
`ifdef QPSK_FRAME_CRC_EN
      crc = ref_crc(crc, w);
      lst = 1'b0;
`else
      lst = (i == len_n - 1);
`endif
      exp_q.push_back({lst, w});
    end
`ifdef QPSK_FRAME_CRC_EN
    exp_q.push_back({1'b1, crc ^ 32'hFFFFFFFF});
`endif
  endtask

  task automatic pulse_enable();
    @(posedge clk); #1 cfg_enable = 1'b1;
    @(posedge clk); #1 cfg_enable = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    chk({nm, "_drain_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // m_tready pattern
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tready_mode) m_if.tready = ~m_if.tready;
      else             m_if.tready = 1'b1;
    end
  end

  // upstream payload source
  initial begin
    bit hs;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = reset_n && s_if.tvalid && s_if.tready;
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        acc_cnt++;
        if (acc_cnt == stall_at) stall_rem = stall_len;
      end
      if (stall_rem > 0) begin
        s_if.tvalid = 1'b0;
        stall_rem--;
      end else if (src_q.size() > 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = src_q[0];
      end else begin
        s_if.tvalid = 1'b0;
      end
    end
  end

  // output monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (s_if.tready) srdy_seen++;
      if (prev_stall) begin
        checks++;
        if (!m_if.tvalid || m_if.tdata !== prev_data || m_if.tlast !== prev_last) begin
          errors++;
          $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h last=%b expected none", m_if.tdata, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_if.tlast, m_if.tdata} !== e) begin
            errors++;
            $display("FAIL word: got %h last=%b expected %h last=%b",
                     m_if.tdata, m_if.tlast, e[31:0], e[32]);
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_tdata", m_if.tdata, 32'd0);
    chk("rst_tlast", {31'd0, m_if.tlast}, 32'd0);
    chk("rst_sready", {31'd0, s_if.tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: basic frame, sink always ready
    cfg_preamble_words = 8'd2;
    cfg_payload_len    = 16'd3;
    push_frame(2, 3, 32'h000000A0);
    pulse_enable();
    wait_drain("t1", 200);
    repeat (32) @(negedge clk);
    chk("t1_gap_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1", 8);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("t1_underrun", {31'd0, underrun}, 32'd0);

    // 2: sink toggles ready every cycle
    tready_mode = 1'b1;
    push_frame(2, 3, 32'h000000A0);
    pulse_enable();
    wait_drain("t2", 400);
    wait_idle("t2", 80);
    tready_mode = 1'b0;
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // 3: no preamble, no payload
    cfg_preamble_words = 8'd0;
    cfg_payload_len    = 16'd0;
    srdy_seen = 0;
    push_frame(0, 0, 32'h0);
    pulse_enable();
    wait_drain("t3", 200);
    wait_idle("t3", 80);
    chk("t3_sready_seen", srdy_seen, 0);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // 4: upstream stall after 2nd payload word
    cfg_preamble_words = 8'd2;
    cfg_payload_len    = 16'd4;
    acc_cnt = 0; stall_at = 2; stall_len = 5;
    push_frame(2, 4, 32'h000000B0);
    pulse_enable();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_rem > 0) break;
    end
    chk("t4_stall_seen", {31'd0, stall_rem > 0}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t4_tvalid_in_stall", {31'd0, m_if.tvalid}, 32'd0);
    chk("t4_underrun_set", {31'd0, underrun}, 32'd1);
    wait_drain("t4", 200);
    wait_idle("t4", 80);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    repeat (5) @(negedge clk);
    chk("t4_underrun_sticky", {31'd0, underrun}, 32'd1);
    stall_at = 0;

    // 5: enable dropped and length edited mid-payload
    cfg_preamble_words = 8'd1;
    cfg_payload_len    = 16'd8;
    acc_cnt = 0;
    push_frame(1, 8, 32'h000000C0);
    @(posedge clk); #1 cfg_enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_underrun_clr", {31'd0, underrun}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt >= 2) break;
    end
    #1 cfg_enable = 1'b0;
    cfg_payload_len = 16'd2;
    wait_drain("t5", 200);
    wait_idle("t5", 80);
    chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd5);
    repeat (3) @(negedge clk);
    chk("t5_stays_idle", {31'd0, busy}, 32'd0);

    // 5b: reset pulsed in the middle of a payload
    cfg_preamble_words = 8'd0;
    cfg_payload_len    = 16'd8;
    acc_cnt = 0;
    push_frame(0, 8, 32'h000000D0);
    pulse_enable();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (acc_cnt >= 2) break;
    end
    #1 reset_n = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    chk("rst2_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst2_tdata", m_if.tdata, 32'd0);
    chk("rst2_tlast", {31'd0, m_if.tlast}, 32'd0);
    chk("rst2_sready", {31'd0, s_if.tready}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst2_underrun", {31'd0, underrun}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

`ifdef QPSK_FRAME_CRC_EN
    // 6: CRC over a single zero word
    cfg_preamble_words = 8'd0;
    cfg_payload_len    = 16'd1;
    exp_q.push_back({1'b0, 32'h1ACFFC1D});
    exp_q.push_back({1'b0, 32'h00000000});
    exp_q.push_back({1'b1, 32'h38FB2284});
    src_q.push_back(32'h00000000);
    pulse_enable();
    wait_drain("t6", 200);
    wait_idle("t6", 80);
    chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
